// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA
// scan-out (each word shown as a 4x4 pixel block) and a host write port.
//
// Ports:
//   clk, rst_n          pixel clock, async active-low reset
//   de_n, vsync_n       active-low display enable / vertical sync
//   wr_valid/addr/data  host write request, held until wr_ready
//   wr_ready            low only in display-read cycles
//   mem_*               single-port RAM (rdata valid one cycle after read)
//   pix_rgb, pix_de_n   registered pixel and delayed enable
//   addr_err            sticky flag for dropped out-of-range writes
module vga_fb_arbiter #(
  parameter int unsigned H_PIX   = 640,
  parameter int unsigned V_LINES = 480,
  parameter int unsigned FB_W    = 160,
  parameter int unsigned FB_H    = 120,
  parameter int unsigned AW      = 15,
  parameter int unsigned DW      = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de_n,
  input  logic          vsync_n,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_rgb,
  output logic          pix_de_n,
  output logic          addr_err
);

  localparam int unsigned CW   = $clog2(H_PIX);
  localparam int unsigned RW   = $clog2(V_LINES);
  localparam int unsigned FB_N = FB_W * FB_H;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_pend;
  logic          r_sync;
  logic          r_de_q;
  logic          r_rd_q;
  logic [DW-1:0] r_n;
  logic [DW-1:0] r_g;
  logic [DW-1:0] r_pix;
  logic          r_pix_de_n;
  logic          r_err;

  logic          w_line_end;
  logic [CW-3:0] w_grp_idx;
  logic          w_grp_rd;
  logic          w_pre_rd;
  logic          w_rd;
  logic [AW-1:0] w_grp;
  logic [AW-1:0] w_line;
  logic [AW-1:0] w_base;
  logic [AW-1:0] w_rd_addr;
  logic          w_acc;
  logic          w_inr;

  assign w_line_end = de_n & ~r_de_q;
  assign w_grp_idx  = r_col[CW-1:2];

  // Fetch the next group one pixel into the current group so it lands
  // in N before the group boundary; disabled until the scan position
  // is known after reset.
  assign w_grp_rd = ~de_n & r_sync
                  & (r_col[1:0] == 2'd1)
                  & (32'(w_grp_idx) < FB_W - 1);

  // Group 0 of the coming line is fetched in horizontal blanking.
  assign w_pre_rd = de_n & r_de_q & r_pend;
  assign w_rd     = w_grp_rd | w_pre_rd;

  assign w_grp  = w_grp_rd ? AW'(w_grp_idx) + AW'(1) : '0;
  assign w_line = AW'(r_row >> 2);

  // Row base = line * FB_W as a sum of shifted copies.
  always_comb begin
    w_base = '0;
    for (int b = 0; b < int'(AW); b++) begin
      if (((FB_W >> b) & 32'd1) != 0) begin
        w_base = w_base + (w_line << b);
      end
    end
  end

  assign w_rd_addr = w_base + w_grp;

  assign wr_ready = rst_n & ~w_rd;
  assign w_acc    = wr_valid & wr_ready;
  assign w_inr    = 32'(wr_addr) < FB_N;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = wr_data;
    if (w_rd) begin
      mem_en   = 1'b1;
      mem_addr = w_rd_addr;
    end else if (w_acc && w_inr) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = wr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_pend     <= 1'b0;
      r_sync     <= 1'b0;
      r_de_q     <= 1'b0;
      r_rd_q     <= 1'b0;
      r_n        <= '0;
      r_g        <= '0;
      r_pix      <= '0;
      r_pix_de_n <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_de_q     <= de_n;
      r_rd_q     <= w_rd;
      r_pix_de_n <= de_n;

      if (r_rd_q) begin
        r_n <= mem_rdata;
      end

      if (w_acc && !w_inr) begin
        r_err <= 1'b1;
      end

      if (!vsync_n) begin
        r_col  <= '0;
        r_row  <= '0;
        r_pend <= 1'b1;
        r_sync <= 1'b1;
      end else if (w_line_end) begin
        r_col  <= '0;
        r_pend <= 1'b1;
        r_sync <= 1'b1;
        if (r_row == RW'(V_LINES - 1)) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        if (!de_n) begin
          r_col <= r_col + 1'b1;
        end
        if (w_pre_rd) begin
          r_pend <= 1'b0;
        end
      end

      if (!de_n) begin
        if (r_col[1:0] == 2'd0) begin
          r_g   <= r_n;
          r_pix <= r_n;
        end else begin
          r_pix <= r_g;
        end
      end else begin
        r_pix <= '0;
      end
    end
  end

  assign pix_rgb  = r_pix;
  assign pix_de_n = r_pix_de_n;
  assign addr_err = r_err;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: random scan/host traffic against a frame-level
// model; per-cycle RAM ops and lagged pixels are scored by a monitor.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de_n = 1'b1;
  logic        vsync_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ready;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] pix_rgb;
  logic        pix_de_n;
  logic        addr_err;

  vga_fb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .de_n      (de_n),
    .vsync_n   (vsync_n),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_rgb   (pix_rgb),
    .pix_de_n  (pix_de_n),
    .addr_err  (addr_err)
  );

  always #20 clk = ~clk;

  // RAM behaviour: word k preloaded with k, read data one cycle later.
  logic [11:0] ram [0:32767];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 32768; k++) ram[k] = 12'(k);
      loaded = 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        en;
    logic        we;
    logic [14:0] addr;
    logic [11:0] data;
    logic        rdy;
  } mrec_t;

  typedef struct {
    int          due;
    logic [11:0] pix;
    logic        de;
    logic        err;
  } prec_t;

  mrec_t qm[$];
  prec_t qp[$];

  int n_chk = 0;
  int n_err = 0;
  bit done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: RAM op and wr_ready of this cycle, pixels due by now.
  always @(negedge clk) begin
    mrec_t m;
    prec_t p;
    if (!rst_n) begin
      chk("rst_pix_rgb", 32'(pix_rgb), 32'h0);
      chk("rst_pix_de_n", 32'(pix_de_n), 32'h1);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_addr_err", 32'(addr_err), 32'h0);
    end else begin
      if (qm.size() > 0) begin
        m = qm.pop_front();
        chk("mem_en", 32'(mem_en), 32'(m.en));
        chk("mem_we", 32'(mem_we), 32'(m.we));
        chk("wr_ready", 32'(wr_ready), 32'(m.rdy));
        if (m.en) chk("mem_addr", 32'(mem_addr), 32'(m.addr));
        if (m.en && m.we) chk("mem_wdata", 32'(mem_wdata), 32'(m.data));
      end
      while (qp.size() > 0 && qp[0].due <= cyc) begin
        p = qp.pop_front();
        chk("pix_rgb", 32'(pix_rgb), 32'(p.pix));
        chk("pix_de_n", 32'(pix_de_n), 32'(p.de));
        chk("addr_err", 32'(addr_err), 32'(p.err));
      end
    end
    if (done) begin
      chk("pix_drain", 32'(qp.size()), 32'h0);
      chk("mem_drain", 32'(qm.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
    end
  end

  // Reference: scan position per the line/frame rules, framebuffer image.
  logic [11:0] ref_fb [0:19199];
  int          m_row = 0;
  int          m_col = 0;
  bit          m_pend = 1'b0;
  bit          m_sync = 1'b0;
  bit          m_deq = 1'b0;
  bit          m_err = 1'b0;
  logic        h_valid = 1'b0;
  logic [14:0] h_addr = '0;
  logic [11:0] h_data = '0;
  int          mode = 0;

  task automatic step(input logic de, input logic vs);
    mrec_t m;
    prec_t p;
    bit    rd;
    int    ra;
    int    idx;
    if (!h_valid && mode != 0 &&
        (mode == 2 || $urandom_range(1, 0) == 1)) begin
      // Target fb rows away from the one being scanned out.
      h_valid = 1'b1;
      h_addr  = 15'(((m_row / 4 + 2 + $urandom_range(99, 0)) % 120) * 160
                    + $urandom_range(159, 0));
      h_data  = 12'($urandom);
    end
    de_n     = de;
    vsync_n  = vs;
    wr_valid = h_valid;
    wr_addr  = h_addr;
    wr_data  = h_data;

    rd = 1'b0;
    ra = 0;
    if (!de && m_sync && m_col % 4 == 1 && m_col / 4 < 159) begin
      rd = 1'b1;
      ra = (m_row / 4) * 160 + m_col / 4 + 1;
    end else if (de && m_deq && m_pend) begin
      rd = 1'b1;
      ra = (m_row / 4) * 160;
      m_pend = 1'b0;
    end

    m.en   = rd;
    m.we   = 1'b0;
    m.addr = 15'(ra);
    m.data = '0;
    m.rdy  = !rd;
    if (h_valid && !rd) begin
      if (h_addr < 15'd19200) begin
        m.en   = 1'b1;
        m.we   = 1'b1;
        m.addr = h_addr;
        m.data = h_data;
        ref_fb[h_addr] = h_data;
      end else begin
        m_err = 1'b1;
      end
      h_valid = 1'b0;
    end
    qm.push_back(m);

    idx   = (m_row / 4) * 160 + m_col / 4;
    p.due = cyc + 1;
    p.de  = de;
    p.err = m_err;
    p.pix = (!de && m_sync && idx < 19200) ? ref_fb[idx] : 12'h000;
    qp.push_back(p);

    if (!vs) begin
      m_row  = 0;
      m_col  = 0;
      m_pend = 1'b1;
      m_sync = 1'b1;
    end else if (de && !m_deq) begin
      m_col  = 0;
      m_row  = (m_row + 1) % 480;
      m_pend = 1'b1;
      m_sync = 1'b1;
    end else if (!de) begin
      m_col = (m_col + 1) % 1024;
    end
    m_deq = de;

    @(posedge clk);
    #1;
  endtask

  task automatic line(input int len, input int blank, input bit vs_end);
    for (int i = 0; i < len; i++) step(1'b0, 1'b1);
    for (int i = 0; i < blank; i++) step(1'b1, !(vs_end && i == 0));
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    qm.delete();
    qp.delete();
    m_row    = 0;
    m_col    = 0;
    m_pend   = 1'b0;
    m_sync   = 1'b0;
    m_deq    = 1'b0;
    m_err    = 1'b0;
    h_valid  = 1'b0;
    wr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 19200; k++) ref_fb[k] = 12'(k);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b1);

    mode = 0;
    repeat (8) line(640, 6, 1'b0);
    mode = 2;
    repeat (4) line(640, 6, 1'b0);
    mode = 1;
    while (m_row != 300) begin
      line(4 * $urandom_range(15, 2), 4 + $urandom_range(2, 0), 1'b0);
    end
    line(40, 6, 1'b1);
    repeat (4) line(640, 6, 1'b0);

    mode = 0;
    repeat (2) step(1'b1, 1'b1);
    h_valid = 1'b1;
    h_addr  = 15'd19200;
    h_data  = 12'habc;
    repeat (3) step(1'b1, 1'b1);
    h_valid = 1'b1;
    h_addr  = 15'd16000;
    h_data  = 12'h5a5;
    repeat (2) step(1'b1, 1'b1);
    repeat (2) line(40, 6, 1'b0);

    for (int i = 0; i < 322; i++) step(1'b0, 1'b1);
    mid_reset();
    for (int i = 0; i < 316; i++) step(1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b1);
    repeat (2) line(640, 6, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    done = 1'b1;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameters: H_PIX 640, active pixels per line; V_LINES 480, active lines per frame; FB_W 160, framebuffer width in words; FB_H 120, framebuffer height; AW 15, address width; DW 12, pixel width {R[11:8],G[7:4],B[3:0]}.
REQ-002 SHALL have ports: clk in 1, 25 MHz pixel clock, single clock domain; rst_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: de_n in 1, active-low display enable from the sync generator; vsync_n in 1, active-low vertical sync.
REQ-004 SHALL have host write ports: wr_valid in 1; wr_addr in AW; wr_data in DW; wr_ready out 1.
REQ-005 SHALL have single-port RAM ports: mem_en out 1; mem_we out 1; mem_addr out AW; mem_wdata out DW; mem_rdata in DW, valid the cycle after mem_en with mem_we=0.
REQ-006 SHALL have pixel outputs: pix_rgb out DW, registered; pix_de_n out 1, de_n delayed 1 cycle; addr_err out 1, sticky.

Function
REQ-007 SHALL track col (10 bit) and row (9 bit); col increments on each cycle with de_n=0.
REQ-008 Line end = de_n=1 while de_n_q=0: SHALL set col<=0, row<=row+1 (479 wraps to 0) and pend<=1.
REQ-009 vsync_n=0 SHALL force row<=0, col<=0, pend<=1; vsync_n takes precedence over line end in the same cycle.
REQ-010 Display address SHALL be (row>>2)*FB_W + grp, computed as shift-add in AW bits; maximum value 19199.
REQ-011 Group fetch: on de_n=0 with col[1:0]=1 and (col>>2)<FB_W-1, SHALL issue a display read with grp=(col>>2)+1.
REQ-012 Line prefetch: on de_n=1, de_n_q=1 and pend=1, SHALL issue a display read with grp=0 and clear pend.
REQ-013 Display read cycle: mem_en=1, mem_we=0, wr_ready=0, and the host write is not accepted.
REQ-014 The cycle after a display read, SHALL load mem_rdata into prefetch register N.
REQ-015 On a de_n=0 cycle: col[1:0]=0 SHALL give G<=N and pix_rgb<=N; otherwise pix_rgb<=G. On a de_n=1 cycle, pix_rgb<=0.
REQ-016 Latency: pix_rgb and pix_de_n SHALL lag de_n by exactly 1 cycle; each fb word SHALL be shown on 4 consecutive pixels and 4 consecutive lines.
REQ-017 wr_ready SHALL be combinational: 1 in every cycle without a display read.
REQ-018 Host transfer accepted iff wr_valid=1 and wr_ready=1; in-range (wr_addr<FB_W*FB_H) SHALL drive mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data in the same cycle.
REQ-019 Out-of-range accepted write SHALL be dropped (mem_en=0) and set addr_err=1.
REQ-020 Host SHALL hold wr_valid, wr_addr and wr_data stable until accepted.
REQ-021 Idle cycles (no read, no accepted write) SHALL drive mem_en=0 and mem_we=0.

Reset
REQ-022 With rst_n=0: col, row, pend, N, G, pix_rgb, de_n_q and addr_err SHALL be 0; pix_de_n SHALL be 1; mem_en and mem_we SHALL be 0.
REQ-023 Reset release mid-frame: SHALL output black until the first line end or vsync_n sets pend; no fetch before that.
REQ-024 Reset asserted during a pending read SHALL discard the returning mem_rdata.

Verification
REQ-025 RAM preloaded with word k=k; after vsync then line end, first blank cycles -> one read at addr 0; pixels 0-3 = 0x000, pixels 4-7 = 0x001.
REQ-026 Line 5 (row=5) -> reads at addr 160..319 in order; pix_rgb groups 160,161,... every 4 pixels.
REQ-027 wr_valid held during active video -> wr_ready=0 exactly on col[1:0]=1 cycles; 3 writes accepted per 4 cycles; no write lost.
REQ-028 wr_addr=19200, wr_valid=1 -> accepted, mem_en=0, addr_err=1 and stays 1 until rst_n=0.
REQ-029 vsync_n=0 on same cycle as line end at row 300 -> row=0, pend=1; next read at addr 0.
REQ-030 rst_n pulsed low at col=321 -> pix_rgb=0 and pix_de_n=1 at once; no mem_en until next line end; then normal output.
